alu_frame_sequencer: RTL and testbench

Controller between the UART core's FIFO interface and the ALU. It pops a three-byte command frame (operand A, operand B, opcode) from the receive FIFO and holds the operands and opcode stable on the ALU inputs. It then latches the ALU result and pushes it into the transmit FIFO. Inter-byte timeout and opcode validation keep the command stream resynchronised after a lost or corrupted byte.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_frame_sequencer_idle_timer.sv | 37 +++
 rtl/alu_frame_sequencer.sv | 160 ++++++++++++++++
 tb/tb_alu_frame_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU frame sequencer: opcode values, FSM state
// encoding and the opcode validity check.
package alu_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
    localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        ST_GET_A  = 3'd0,
        ST_GET_B  = 3'd1,
        ST_GET_OP = 3'd2,
        ST_EXEC   = 3'd3,
        ST_SEND   = 3'd4
    } state_t;

    function automatic logic is_valid_op(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_valid_op = 1'b1;
            default:                        is_valid_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_frame_sequencer_idle_timer.sv
// Idle-cycle counter: clears on demand, counts while enabled and flags when
// it sits on its last count (LIMIT-1).
module idle_timer #(
    parameter int LIMIT = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expired = (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/alu_frame_sequencer.sv
// Pops {A, B, opcode} frames from the RX FIFO, presents them to the ALU and
// pushes the result (or an error byte) into the TX FIFO.
module alu_frame_sequencer
    import alu_pkg::*;
#(
    parameter int                BUS_SIZE       = 8,
    parameter int                OP_SIZE        = 6,
    parameter int                TIMEOUT_CYCLES = 1_000_000,
    parameter logic [BUS_SIZE-1:0] ERR_BYTE     = 8'hFF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_rx_empty,
    input  logic [BUS_SIZE-1:0] i_rx_data,
    output logic                o_rd_uart,
    input  logic                i_tx_full,
    output logic                o_wr_uart,
    output logic [BUS_SIZE-1:0] o_tx_data,
    output logic [BUS_SIZE-1:0] o_op_a,
    output logic [BUS_SIZE-1:0] o_op_b,
    output logic [OP_SIZE-1:0]  o_op_code,
    input  logic [BUS_SIZE-1:0] i_alu_result,
    output logic [BUS_SIZE-1:0] o_result,
    output logic                o_busy,
    output logic                o_frame_err,
    output logic                o_op_err
);

    state_t state_q, state_d;

    logic [BUS_SIZE-1:0] op_a_q, op_a_d;
    logic [BUS_SIZE-1:0] op_b_q, op_b_d;
    logic [OP_SIZE-1:0]  op_code_q, op_code_d;
    logic                op_valid_q, op_valid_d;
    logic [BUS_SIZE-1:0] result_q, result_d;
    logic [BUS_SIZE-1:0] tx_data_q, tx_data_d;
    logic                frame_err_q, frame_err_d;
    logic                op_err_q, op_err_d;

    logic capture_state;
    logic wait_state;
    logic rd_en;
    logic wr_en;
    logic expired;
    logic timeout_fire;
    logic rx_op_valid;

    assign capture_state = (state_q == ST_GET_A) || (state_q == ST_GET_B) || (state_q == ST_GET_OP);
    assign wait_state    = (state_q == ST_GET_B) || (state_q == ST_GET_OP);
    assign rd_en         = capture_state && !i_rx_empty;
    assign wr_en         = (state_q == ST_SEND) && !i_tx_full;
    assign timeout_fire  = wait_state && i_rx_empty && expired;

    // Upper opcode-byte bits must be zero for the low bits to be trusted.
    assign rx_op_valid = ((i_rx_data >> OP_SIZE) == '0) && is_valid_op(i_rx_data[OP_SIZE-1:0]);

    idle_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (rd_en || !wait_state),
        .i_enable  (wait_state && i_rx_empty),
        .o_expired (expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_GET_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_GET_A:  if (!i_rx_empty) state_d = ST_GET_B;
            ST_GET_B: begin
                if (!i_rx_empty)  state_d = ST_GET_OP;
                else if (expired) state_d = ST_GET_A;
            end
            ST_GET_OP: begin
                if (!i_rx_empty)  state_d = ST_EXEC;
                else if (expired) state_d = ST_GET_A;
            end
            ST_EXEC:   state_d = ST_SEND;
            ST_SEND:   if (!i_tx_full) state_d = ST_GET_A;
            default:   state_d = ST_GET_A;
        endcase
    end

    // Strobes are gated by reset so the FIFOs never see a pop/push in reset.
    always_comb begin
        o_rd_uart = i_rst_n && rd_en;
        o_wr_uart = i_rst_n && wr_en;
        o_busy    = (state_q != ST_GET_A);
    end

    always_comb begin
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_code_d   = op_code_q;
        op_valid_d  = op_valid_q;
        result_d    = result_q;
        tx_data_d   = tx_data_q;
        frame_err_d = timeout_fire;
        op_err_d    = 1'b0;
        if (rd_en) begin
            case (state_q)
                ST_GET_A: op_a_d = i_rx_data;
                ST_GET_B: op_b_d = i_rx_data;
                default: begin
                    op_valid_d = rx_op_valid;
                    if (rx_op_valid) op_code_d = i_rx_data[OP_SIZE-1:0];
                end
            endcase
        end
        if (state_q == ST_EXEC) begin
            if (op_valid_q) begin
                result_d  = i_alu_result;
                tx_data_d = i_alu_result;
            end else begin
                tx_data_d = ERR_BYTE;
                op_err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_code_q   <= '0;
            op_valid_q  <= 1'b0;
            result_q    <= '0;
            tx_data_q   <= '0;
            frame_err_q <= 1'b0;
            op_err_q    <= 1'b0;
        end else begin
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_code_q   <= op_code_d;
            op_valid_q  <= op_valid_d;
            result_q    <= result_d;
            tx_data_q   <= tx_data_d;
            frame_err_q <= frame_err_d;
            op_err_q    <= op_err_d;
        end
    end

    assign o_op_a      = op_a_q;
    assign o_op_b      = op_b_q;
    assign o_op_code   = op_code_q;
    assign o_result    = result_q;
    assign o_tx_data   = tx_data_q;
    assign o_frame_err = frame_err_q;
    assign o_op_err    = op_err_q;

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Bench for alu_frame_sequencer: FIFO and ALU models around the DUT, a
// frame table checked through a TX scoreboard, plus timeout/stall/reset cases.
module tb_alu_frame_sequencer;

    localparam int BW = 8;
    localparam int OW = 6;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_empty;
    logic [BW-1:0] rx_data;
    logic          rd_uart;
    logic          tx_full = 1'b0;
    logic          wr_uart;
    logic [BW-1:0] tx_data;
    logic [BW-1:0] op_a, op_b;
    logic [OW-1:0] op_code;
    logic [BW-1:0] alu_result;
    logic [BW-1:0] result;
    logic          busy, frame_err, op_err;

    always #5 clk = ~clk;

    alu_frame_sequencer #(
        .BUS_SIZE       (BW),
        .OP_SIZE        (OW),
        .TIMEOUT_CYCLES (TO),
        .ERR_BYTE       (8'hFF)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_empty   (rx_empty),
        .i_rx_data    (rx_data),
        .o_rd_uart    (rd_uart),
        .i_tx_full    (tx_full),
        .o_wr_uart    (wr_uart),
        .o_tx_data    (tx_data),
        .o_op_a       (op_a),
        .o_op_b       (op_b),
        .o_op_code    (op_code),
        .i_alu_result (alu_result),
        .o_result     (result),
        .o_busy       (busy),
        .o_frame_err  (frame_err),
        .o_op_err     (op_err)
    );

    // Environment ALU
    always_comb begin
        logic signed [BW-1:0] sa;
        sa = op_a;
        alu_result = '0;
        case (op_code)
            6'b100000: alu_result = op_a + op_b;
            6'b100010: alu_result = op_a - op_b;
            6'b100100: alu_result = op_a & op_b;
            6'b100101: alu_result = op_a | op_b;
            6'b100110: alu_result = op_a ^ op_b;
            6'b100111: alu_result = ~(op_a | op_b);
            6'b000011: alu_result = sa >>> op_b;
            6'b000010: alu_result = op_a >> op_b;
            default:   alu_result = '0;
        endcase
    end

    // First-word fall-through RX FIFO model
    logic [BW-1:0] rx_q[$];
    logic          rd_seen = 1'b0;
    always @(negedge clk) rd_seen = rd_uart;
    always @(posedge clk) begin
        #1;
        if (rd_seen && rx_q.size() > 0) void'(rx_q.pop_front());
    end
    always @(*) begin
        rx_empty = (rx_q.size() == 0);
        rx_data  = (rx_q.size() > 0) ? rx_q[0] : '0;
    end

    int n_vec = 0;
    int n_err = 0;
    int rd_cnt = 0, wr_cnt = 0, operr_cnt = 0, frerr_cnt = 0;
    logic [BW-1:0] exp_tx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse counters and TX scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (rd_uart)   rd_cnt++;
        if (op_err)    operr_cnt++;
        if (frame_err) frerr_cnt++;
        if (wr_uart) begin
            wr_cnt++;
            n_vec++;
            if (exp_tx_q.size() == 0) begin
                n_err++;
                $display("FAIL tx_unexpected: got %0h expected no push", tx_data);
            end else begin
                logic [BW-1:0] e;
                e = exp_tx_q.pop_front();
                if (tx_data !== e) begin
                    n_err++;
                    $display("FAIL tx_data: got %0h expected %0h", tx_data, e);
                end else begin
                    $display("push tx_data=%0h", tx_data);
                end
            end
        end
    end

    typedef struct {
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        logic [BW-1:0] op;
        logic [BW-1:0] exp_tx;
        logic          exp_err;
    } vec_t;

    vec_t vecs[11];
    logic [BW-1:0] exp_result = '0;

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_wr(input int start, input string name);
        int k;
        k = 0;
        while (wr_cnt <= start && k < 300) begin
            @(posedge clk);
            k++;
        end
        #2;
        if (wr_cnt <= start) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no push expected push", name);
        end
    endtask

    task automatic run_frame(input vec_t v);
        int rd0, wr0, oe0;
        rd0 = rd_cnt; wr0 = wr_cnt; oe0 = operr_cnt;
        exp_tx_q.push_back(v.exp_tx);
        if (!v.exp_err) exp_result = v.exp_tx;
        rx_q.push_back(v.a); rx_q.push_back(v.b); rx_q.push_back(v.op);
        wait_wr(wr0, "frame");
        wait_cycles(3);
        $display("frame a=%0h b=%0h op=%0h -> result=%0h", v.a, v.b, v.op, result);
        check("result", result, exp_result);
        check("rd_pulses", rd_cnt - rd0, 3);
        check("wr_pulses", wr_cnt - wr0, 1);
        check("op_err_pulses", operr_cnt - oe0, v.exp_err ? 1 : 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        int rd0, wr0, fe0;
        vecs[0]  = '{8'h05, 8'h03, 8'h20, 8'h08, 1'b0};
        vecs[1]  = '{8'hFB, 8'h02, 8'h03, 8'hFE, 1'b0};
        vecs[2]  = '{8'h01, 8'h02, 8'h3F, 8'hFF, 1'b1};
        vecs[3]  = '{8'h10, 8'h01, 8'h02, 8'h08, 1'b0};
        vecs[4]  = '{8'h0C, 8'h0A, 8'h25, 8'h0E, 1'b0};
        vecs[5]  = '{8'h0C, 8'h0A, 8'h26, 8'h06, 1'b0};
        vecs[6]  = '{8'h0C, 8'h0A, 8'h27, 8'hF1, 1'b0};
        vecs[7]  = '{8'h80, 8'h01, 8'h03, 8'hC0, 1'b0};
        vecs[8]  = '{8'h41, 8'h02, 8'h60, 8'hFF, 1'b1};
        vecs[9]  = '{8'h0F, 8'h0A, 8'h22, 8'h05, 1'b0};
        vecs[10] = '{8'h06, 8'h03, 8'h24, 8'h02, 1'b0};

        wait_cycles(3);
        check("rst_outputs", {op_a, op_b, 2'b00, op_code, result, tx_data}, 32'h0);
        check("rst_flags", {busy, frame_err, op_err, rd_uart, wr_uart}, 5'b0);
        rst_n = 1'b1;
        wait_cycles(2);

        for (int i = 0; i < 9; i++) run_frame(vecs[i]);

        // Lone byte followed by silence must time out and resynchronise
        rd0 = rd_cnt; fe0 = frerr_cnt;
        rx_q.push_back(8'h77);
        wait_cycles(TO + 20);
        $display("timeout frame_err_pulses=%0d", frerr_cnt - fe0);
        check("timeout_frame_err", frerr_cnt - fe0, 1);
        check("timeout_busy", busy, 0);
        check("timeout_op_a_kept", op_a, 8'h77);
        check("timeout_rd", rd_cnt - rd0, 1);
        run_frame(vecs[9]);

        // TX full stall with a second frame queued behind it
        tx_full = 1'b1;
        rd0 = rd_cnt; wr0 = wr_cnt;
        exp_tx_q.push_back(8'h08);
        exp_tx_q.push_back(8'h0E);
        rx_q.push_back(8'h05); rx_q.push_back(8'h03); rx_q.push_back(8'h20);
        rx_q.push_back(8'h0C); rx_q.push_back(8'h0A); rx_q.push_back(8'h25);
        wait_cycles(10);
        check("stall_rd_before", rd_cnt - rd0, 3);
        rd0 = rd_cnt;
        wait_cycles(50);
        $display("stall rd_during=%0d wr_during=%0d", rd_cnt - rd0, wr_cnt - wr0);
        check("stall_no_pop", rd_cnt - rd0, 0);
        check("stall_no_push", wr_cnt - wr0, 0);
        check("stall_busy", busy, 1);
        tx_full = 1'b0;
        wait_cycles(20);
        exp_result = 8'h0E;
        check("stall_wr_total", wr_cnt - wr0, 2);
        check("stall_result", result, exp_result);

        // Reset in GET_OP after two bytes
        rd0 = rd_cnt;
        rx_q.push_back(8'h33); rx_q.push_back(8'h44);
        wait_cycles(4);
        check("prereset_rd", rd_cnt - rd0, 2);
        rst_n = 1'b0;
        #1;
        check("reset_outputs", {op_a, op_b, 2'b00, op_code, result, tx_data}, 32'h0);
        check("reset_flags", {busy, frame_err, op_err, rd_uart, wr_uart}, 5'b0);
        exp_result = '0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(1);
        run_frame(vecs[10]);

        check("scoreboard_empty", exp_tx_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
